// File: rtl/mips_run_ctrl_if.sv
// Run-controller bus: start/abort/halt requests in, core reset and run status out.
// The master side is the board/top level (or a bench); the slave side is mips_run_ctrl.
interface mips_run_ctrl_if #(
  parameter int unsigned NUM_CORES = 1,
  parameter int unsigned CNT_W     = 16
);
  logic                 start;
  logic                 abort;
  logic [NUM_CORES-1:0] core_halt;
  logic [NUM_CORES-1:0] core_reset;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic                 aborted;
  logic [NUM_CORES-1:0] halted_mask;
  logic [CNT_W-1:0]     cycle_count;

  modport master (
    output start, abort, core_halt,
    input  core_reset, busy, done, timeout, aborted, halted_mask, cycle_count
  );

  modport slave (
    input  start, abort, core_halt,
    output core_reset, busy, done, timeout, aborted, halted_mask, cycle_count
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for one or more MIPS cores: holds the cores in reset for RST_CYCLES,
// releases them, counts RUN cycles and ends the run on all-halt, abort or (optionally)
// a cycle-budget watchdog.
// Optional feature: define RUN_WATCHDOG_EN to compile in the RUN_CYCLES watchdog.
module mips_run_ctrl #(
  parameter int unsigned NUM_CORES  = 1,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned RUN_CYCLES = 6,
  parameter int unsigned CNT_W      = 16
) (
  input logic           clock,
  input logic           reset,
  mips_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RstLast = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e               state_q, state_d;
  logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic                 timeout_q, timeout_d;
  logic                 aborted_q, aborted_d;
  logic                 wd_expire;

`ifdef RUN_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(RUN_CYCLES - 1);
  // Expire on the edge where the count would step up to RUN_CYCLES.
  assign wd_expire = (cnt_q == WdLast);
`else
  logic unused_run_cycles;
  assign unused_run_cycles = (RUN_CYCLES == 0);
  assign wd_expire = 1'b0;
`endif

  // State and status registers; async reset forces every output to its idle value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and status update; RUN exit priority is abort, then all-halt, then watchdog.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    timeout_d = timeout_q;
    aborted_d = aborted_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StReset;
          rst_cnt_d = '0;
          cnt_d     = '0;
          mask_d    = '0;
          timeout_d = 1'b0;
          aborted_d = 1'b0;
        end
      end
      StReset: begin
        if (bus.abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else if (rst_cnt_q == RstLast) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // Count and halt flags advance on every RUN edge, including the exit edge.
        cnt_d  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        mask_d = mask_q | bus.core_halt;
        if (bus.abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else if (&(mask_q | bus.core_halt)) begin
          state_d = StDone;
        end else if (wd_expire) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All outputs are flop outputs or decodes of the state register only.
  assign bus.core_reset  = {NUM_CORES{state_q == StRun}};
  assign bus.busy        = (state_q == StReset) || (state_q == StRun);
  assign bus.done        = (state_q == StDone);
  assign bus.timeout     = timeout_q;
  assign bus.aborted     = aborted_q;
  assign bus.halted_mask = mask_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a table of per-edge vectors for the main run sequences plus
// hand-written sequences for async reset and the watchdog / no-watchdog run length.
module tb_mips_run_ctrl;

  localparam int unsigned NC = 2;
  localparam int unsigned CW = 16;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mips_run_ctrl_if #(.NUM_CORES(NC), .CNT_W(CW)) bus ();

  mips_run_ctrl #(
    .NUM_CORES (NC),
    .RST_CYCLES(2),
    .RUN_CYCLES(6),
    .CNT_W     (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Packed view: {busy, done, core_reset[1:0], timeout, aborted, halted_mask[1:0], count[15:0]}
  typedef struct {
    logic        start;
    logic        abort;
    logic [1:0]  halt;
    logic [23:0] want;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  function automatic logic [23:0] pk(logic b, logic d, logic [1:0] cr, logic to, logic ab,
                                     logic [1:0] hm, logic [15:0] cc);
    return {b, d, cr, to, ab, hm, cc};
  endfunction

  function automatic vec_t mk(logic s, logic a, logic [1:0] h, logic b, logic d,
                              logic [1:0] cr, logic to, logic ab, logic [1:0] hm,
                              logic [15:0] cc);
    vec_t v;
    v.start = s;
    v.abort = a;
    v.halt  = h;
    v.want  = pk(b, d, cr, to, ab, hm, cc);
    return v;
  endfunction

  function automatic logic [23:0] outs();
    return {bus.busy, bus.done, bus.core_reset, bus.timeout, bus.aborted, bus.halted_mask,
            bus.cycle_count};
  endfunction

  task automatic check(input string name, input logic [23:0] want);
    logic [23:0] act;
    act = outs();
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, want);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_to_run(input string name);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check(name, pk(1, 0, 2'b11, 0, 0, 2'b00, 16'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.core_halt = '0;

    //           st ab halt   busy done cr    to ab hm     cc
    vecs.push_back(mk(1, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 16'd0));  // start -> RESET
    vecs.push_back(mk(0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 16'd0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 0, 2'b11, 0, 0, 2'b00, 16'd0));  // RUN cycle 1
    vecs.push_back(mk(0, 0, 2'b00, 1, 0, 2'b11, 0, 0, 2'b00, 16'd1));
    vecs.push_back(mk(0, 0, 2'b00, 1, 0, 2'b11, 0, 0, 2'b00, 16'd2));
    vecs.push_back(mk(0, 0, 2'b01, 1, 0, 2'b11, 0, 0, 2'b01, 16'd3));  // core 0 halts
    vecs.push_back(mk(1, 0, 2'b00, 1, 0, 2'b11, 0, 0, 2'b01, 16'd4));  // start while busy
    vecs.push_back(mk(0, 0, 2'b10, 0, 1, 2'b00, 0, 0, 2'b11, 16'd5));  // all halted -> DONE
    vecs.push_back(mk(0, 1, 2'b00, 0, 1, 2'b00, 0, 0, 2'b11, 16'd5));  // abort ignored in DONE
    vecs.push_back(mk(1, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 16'd0));  // restart clears status
    vecs.push_back(mk(0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 16'd0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 0, 2'b11, 0, 0, 2'b00, 16'd0));
    vecs.push_back(mk(0, 1, 2'b11, 0, 1, 2'b00, 0, 1, 2'b11, 16'd1));  // abort beats all-halt
    vecs.push_back(mk(1, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 16'd0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 1, 2'b00, 0, 1, 2'b00, 16'd0));  // abort in RESET
    vecs.push_back(mk(1, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 16'd0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 16'd0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 0, 2'b11, 0, 0, 2'b00, 16'd0));
    vecs.push_back(mk(0, 0, 2'b11, 0, 1, 2'b00, 0, 0, 2'b11, 16'd1));  // both halt at once
    vecs.push_back(mk(0, 0, 2'b00, 0, 1, 2'b00, 0, 0, 2'b11, 16'd1));  // DONE holds

    // Reset values while reset is held, then after release.
    #12;
    check("reset_held", pk(0, 0, 2'b00, 0, 0, 2'b00, 16'd0));
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("idle_after_reset", pk(0, 0, 2'b00, 0, 0, 2'b00, 16'd0));

    foreach (vecs[i]) begin
      bus.start     = vecs[i].start;
      bus.abort     = vecs[i].abort;
      bus.core_halt = vecs[i].halt;
      tick();
      check($sformatf("vec%0d", i), vecs[i].want);
    end
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.core_halt = '0;

    // Async reset between edges in RUN.
    run_to_run("async_run_entry");
    tick();
    tick();
    check("async_pre", pk(1, 0, 2'b11, 0, 0, 2'b00, 16'd2));
    #3;
    reset = 1'b1;
    #1;
    check("async_immediate", pk(0, 0, 2'b00, 0, 0, 2'b00, 16'd0));
    tick();
    reset = 1'b0;
    tick();
    check("async_idle", pk(0, 0, 2'b00, 0, 0, 2'b00, 16'd0));

`ifdef RUN_WATCHDOG_EN
    // Budget of 6 RUN cycles with no halts.
    run_to_run("wd_run_entry");
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("wd_run%0d", i), pk(1, 0, 2'b11, 0, 0, 2'b00, 16'(i)));
    end
    tick();
    check("wd_expire", pk(0, 1, 2'b00, 1, 0, 2'b00, 16'd6));
    // All-halt on the expiry edge wins over the watchdog.
    run_to_run("wd2_run_entry");
    for (int i = 1; i <= 5; i++) tick();
    bus.core_halt = 2'b11;
    tick();
    bus.core_halt = '0;
    check("wd_vs_halt", pk(0, 1, 2'b00, 0, 0, 2'b11, 16'd6));
`else
    // Without the watchdog the run continues past RUN_CYCLES until all cores halt.
    run_to_run("nowd_run_entry");
    for (int i = 1; i <= 8; i++) tick();
    check("nowd_still_running", pk(1, 0, 2'b11, 0, 0, 2'b00, 16'd8));
    bus.core_halt = 2'b11;
    tick();
    bus.core_halt = '0;
    check("nowd_halt_exit", pk(0, 1, 2'b00, 0, 0, 2'b11, 16'd9));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
